// File: rtl/nfc_phy_pkg.sv
// Shared types and PO bus constants for the NFC SDR latch cycle sequencer.
package nfc_phy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WE_LOW,
    WE_HIGH,
    HOLD,
    RELEASE
  } latchState_t;

  localparam int unsigned PO_DQ_WIDTH   = 32;
  localparam int unsigned PO_DQS_WIDTH  = 8;
  localparam int unsigned PO_CTRL_WIDTH = 4;

  localparam logic [PO_CTRL_WIDTH-1:0] PO_WE_IDLE = 4'hF;
  localparam logic [PO_CTRL_WIDTH-1:0] PO_RE_IDLE = 4'hF;
  localparam logic [PO_CTRL_WIDTH-1:0] PO_LE_ON   = 4'hF;

  // One latched byte request as held through its latch cycle.
  typedef struct packed {
    logic       isAddress;
    logic       isLast;
    logic [7:0] data;
  } latchCmd_t;

  function automatic int unsigned maxOf4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Byte on both ODDR rising-edge lanes, falling-edge lanes zero.
  function automatic logic [PO_DQ_WIDTH-1:0] formatDq(input logic [7:0] data);
    return {8'h00, data, 8'h00, data};
  endfunction

endpackage

// File: rtl/nfc_latch_cycle_sequencer_if.sv
// Byte-request handshake between a command issuer and the latch cycle sequencer.
interface nfc_latch_cycle_sequencer_if #(
  parameter int unsigned NumberOfWays = 4
);
  logic                    iLatchValid;
  logic                    oLatchReady;
  logic                    iLatchIsAddress;
  logic [7:0]              iLatchByte;
  logic [NumberOfWays-1:0] iTargetWay;
  logic                    iLatchLast;

  modport master (
    output iLatchValid, iLatchIsAddress, iLatchByte, iTargetWay, iLatchLast,
    input  oLatchReady
  );

  modport slave (
    input  iLatchValid, iLatchIsAddress, iLatchByte, iTargetWay, iLatchLast,
    output oLatchReady
  );
endinterface

// File: rtl/nfc_phase_timer.sv
// Loadable down-counter timing each latch phase; expired is registered alongside the value.
module nfc_phase_timer #(
  parameter int unsigned Width = 2
) (
  input  logic             iSystemClock,
  input  logic             iModuleReset,
  input  logic             iLoad,
  input  logic [Width-1:0] iLoadValue,
  output logic [Width-1:0] oValue,
  output logic             oExpired
);

  always_ff @(posedge iSystemClock) begin
    if (iModuleReset) begin
      oValue   <= '0;
      oExpired <= 1'b1;
    end else if (iLoad) begin
      oValue   <= iLoadValue;
      oExpired <= (iLoadValue == '0);
    end else if (oValue != '0) begin
      oValue   <= oValue - Width'(1);
      oExpired <= (oValue == Width'(1));
    end
  end

endmodule

// File: rtl/nfc_latch_cycle_sequencer.sv
// SDR command/address latch sequencer: turns each accepted byte into one NAND WE# latch
// cycle and presents pre-formatted, registered PO_* buses to the ODDR output stage.
module nfc_latch_cycle_sequencer
  import nfc_phy_pkg::*;
#(
  parameter int unsigned NumberOfWays = 4,
  parameter int unsigned SetupCycles  = 1,
  parameter int unsigned WPCycles     = 2,
  parameter int unsigned WHCycles     = 2,
  parameter int unsigned HoldCycles   = 1
) (
  input  logic                          iSystemClock,
  input  logic                          iModuleReset,
  nfc_latch_cycle_sequencer_if.slave    latchIf,
  output logic                          oBusy,
  output logic                          oLatchDone,
  output logic                          oWayError,
  output logic                          oDQSOutEnable,
  output logic                          oDQOutEnable,
  output logic [PO_DQS_WIDTH-1:0]       oPO_DQStrobe,
  output logic [PO_DQ_WIDTH-1:0]        oPO_DQ,
  output logic [2*NumberOfWays-1:0]     oPO_ChipEnable,
  output logic [PO_CTRL_WIDTH-1:0]      oPO_ReadEnable,
  output logic [PO_CTRL_WIDTH-1:0]      oPO_WriteEnable,
  output logic [PO_CTRL_WIDTH-1:0]      oPO_AddressLatchEnable,
  output logic [PO_CTRL_WIDTH-1:0]      oPO_CommandLatchEnable
);

  localparam int unsigned MaxCycles  = maxOf4(SetupCycles, WPCycles, WHCycles, HoldCycles);
  localparam int unsigned PhaseWidth = $clog2(MaxCycles + 1);
  localparam int unsigned CeWidth    = 2 * NumberOfWays;

  localparam logic [PhaseWidth-1:0] SetupLoad = PhaseWidth'(SetupCycles - 1);
  localparam logic [PhaseWidth-1:0] WPLoad    = PhaseWidth'(WPCycles - 1);
  localparam logic [PhaseWidth-1:0] WHLoad    = PhaseWidth'(WHCycles - 1);
  localparam logic [PhaseWidth-1:0] HoldLoad  = PhaseWidth'(HoldCycles - 1);

  latchState_t             state, nextState;
  latchCmd_t               rCmd, nextCmd;
  logic [NumberOfWays-1:0] rWay, nextWay;
  logic                    rPending, nextPending;

  logic                    phaseLoad;
  logic [PhaseWidth-1:0]   phaseLoadValue;
  logic [PhaseWidth-1:0]   phaseValue;
  logic                    phaseExpired;

  logic                    accept, wayZero, wayChange, ceOpen, lastHoldNext;
  logic                    nReady, nBusy, nDone, nWayError, nDqOe;
  logic [PO_DQ_WIDTH-1:0]  nDq;
  logic [CeWidth-1:0]      nCe;
  logic [PO_CTRL_WIDTH-1:0] nWe, nAle, nCle;

  nfc_phase_timer #(.Width(PhaseWidth)) uPhaseTimer (
    .iSystemClock (iSystemClock),
    .iModuleReset (iModuleReset),
    .iLoad        (phaseLoad),
    .iLoadValue   (phaseLoadValue),
    .oValue       (phaseValue),
    .oExpired     (phaseExpired)
  );

  assign accept    = latchIf.iLatchValid & latchIf.oLatchReady;
  assign wayZero   = (latchIf.iTargetWay == '0);
  assign wayChange = (latchIf.iTargetWay != rWay);
  assign ceOpen    = (oPO_ChipEnable != '1);

  assign oDQSOutEnable  = 1'b0;
  assign oPO_DQStrobe   = '0;
  assign oPO_ReadEnable = PO_RE_IDLE;

  // Next state, request capture, and next registered output values.
  always_comb begin
    nextState      = state;
    nextCmd        = rCmd;
    nextWay        = rWay;
    nextPending    = rPending;
    phaseLoad      = 1'b0;
    phaseLoadValue = '0;
    nWayError      = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          if (wayZero) begin
            nWayError = 1'b1;
          end else begin
            nextCmd.isAddress = latchIf.iLatchIsAddress;
            nextCmd.isLast    = latchIf.iLatchLast;
            nextCmd.data      = latchIf.iLatchByte;
            nextWay           = latchIf.iTargetWay;
            if (ceOpen && wayChange) begin
              nextState   = RELEASE;
              nextPending = 1'b1;
            end else begin
              nextState      = SETUP;
              phaseLoad      = 1'b1;
              phaseLoadValue = SetupLoad;
            end
          end
        end
      end
      SETUP: begin
        if (phaseExpired) begin
          nextState      = WE_LOW;
          phaseLoad      = 1'b1;
          phaseLoadValue = WPLoad;
        end
      end
      WE_LOW: begin
        if (phaseExpired) begin
          nextState      = WE_HIGH;
          phaseLoad      = 1'b1;
          phaseLoadValue = WHLoad;
        end
      end
      WE_HIGH: begin
        if (phaseExpired) begin
          nextState      = HOLD;
          phaseLoad      = 1'b1;
          phaseLoadValue = HoldLoad;
        end
      end
      HOLD: begin
        if (phaseExpired) begin
          if (rCmd.isLast) begin
            nextState = RELEASE;
          end else if (accept && wayZero) begin
            nWayError = 1'b1;
            nextState = IDLE;
          end else if (accept) begin
            nextCmd.isAddress = latchIf.iLatchIsAddress;
            nextCmd.isLast    = latchIf.iLatchLast;
            nextCmd.data      = latchIf.iLatchByte;
            nextWay           = latchIf.iTargetWay;
            if (wayChange) begin
              nextState   = RELEASE;
              nextPending = 1'b1;
            end else begin
              nextState      = SETUP;
              phaseLoad      = 1'b1;
              phaseLoadValue = SetupLoad;
            end
          end else begin
            nextState = IDLE;
          end
        end
      end
      RELEASE: begin
        if (rPending) begin
          nextState      = SETUP;
          nextPending    = 1'b0;
          phaseLoad      = 1'b1;
          phaseLoadValue = SetupLoad;
        end else begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase

    // The cycle after this edge is the final HOLD cycle of the byte.
    lastHoldNext = (nextState == HOLD) &&
                   ((state == HOLD) ? (phaseValue == PhaseWidth'(1)) : (HoldLoad == '0));
    nBusy  = (nextState != IDLE);
    nDone  = lastHoldNext;
    nReady = (nextState == IDLE) || (lastHoldNext && !nextCmd.isLast);

    nWe   = PO_WE_IDLE;
    nDqOe = 1'b0;
    nDq   = oPO_DQ;
    nCe   = oPO_ChipEnable;
    nAle  = '0;
    nCle  = '0;
    unique case (nextState)
      SETUP, WE_LOW, WE_HIGH, HOLD: begin
        nCe  = ~{2{nextWay}};
        nCle = nextCmd.isAddress ? '0 : PO_LE_ON;
        nAle = nextCmd.isAddress ? PO_LE_ON : '0;
        if (nextState != HOLD) begin
          nDqOe = 1'b1;
          nDq   = formatDq(nextCmd.data);
        end
        if (nextState == WE_LOW) nWe = '0;
      end
      RELEASE: nCe = '1;
      default: ;
    endcase
  end

  always_ff @(posedge iSystemClock) begin
    if (iModuleReset) begin
      state                  <= IDLE;
      rCmd                   <= '0;
      rWay                   <= '0;
      rPending               <= 1'b0;
      latchIf.oLatchReady    <= 1'b1;
      oBusy                  <= 1'b0;
      oLatchDone             <= 1'b0;
      oWayError              <= 1'b0;
      oDQOutEnable           <= 1'b0;
      oPO_DQ                 <= '0;
      oPO_ChipEnable         <= '1;
      oPO_WriteEnable        <= PO_WE_IDLE;
      oPO_AddressLatchEnable <= '0;
      oPO_CommandLatchEnable <= '0;
    end else begin
      state                  <= nextState;
      rCmd                   <= nextCmd;
      rWay                   <= nextWay;
      rPending               <= nextPending;
      latchIf.oLatchReady    <= nReady;
      oBusy                  <= nBusy;
      oLatchDone             <= nDone;
      oWayError              <= nWayError;
      oDQOutEnable           <= nDqOe;
      oPO_DQ                 <= nDq;
      oPO_ChipEnable         <= nCe;
      oPO_WriteEnable        <= nWe;
      oPO_AddressLatchEnable <= nAle;
      oPO_CommandLatchEnable <= nCle;
    end
  end

endmodule
